// File: rtl/blk_col2row_buf.sv
// Ping-pong 8x8 transpose buffer: accepts column-pair beats and re-emits each block as row-pair beats.
// Two banks let one block fill while the other drains.
module blk_col2row_buf #(
  parameter  int DATA_WIDTH = 8,
  localparam int EW         = DATA_WIDTH + 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             col_vld,
  output logic             col_rdy,
  input  logic [16*EW-1:0] col_data,
  output logic             row_vld,
  input  logic             row_rdy,
  output logic [16*EW-1:0] row_data,
  output logic             blk_done
);

  // mem_reg[bank][row][col]
  logic [EW-1:0] mem_reg [2][8][8];
  logic [1:0]    full_reg;
  logic [1:0]    full_next;
  logic          wr_bank_reg;
  logic          rd_bank_reg;
  logic [1:0]    wr_beat_reg;
  logic [1:0]    rd_beat_reg;
  logic          blk_done_reg;

  logic col_acc;
  logic row_acc;
  logic wr_last;
  logic rd_last;

  assign col_rdy  = ~full_reg[wr_bank_reg];
  assign row_vld  = full_reg[rd_bank_reg];
  assign blk_done = blk_done_reg;

  assign col_acc = col_vld & col_rdy;
  assign row_acc = row_vld & row_rdy;
  assign wr_last = col_acc & (wr_beat_reg == 2'd3);
  assign rd_last = row_acc & (rd_beat_reg == 2'd3);

  // Fill completion and drain completion always target different banks, so both apply.
  always_comb begin
    full_next = full_reg;
    if (wr_last) full_next[wr_bank_reg] = 1'b1;
    if (rd_last) full_next[rd_bank_reg] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg     <= 2'b00;
      wr_bank_reg  <= 1'b0;
      rd_bank_reg  <= 1'b0;
      wr_beat_reg  <= 2'd0;
      rd_beat_reg  <= 2'd0;
      blk_done_reg <= 1'b0;
    end else begin
      full_reg     <= full_next;
      blk_done_reg <= rd_last;
      if (col_acc) begin
        wr_beat_reg <= wr_beat_reg + 2'd1;
        if (wr_last) wr_bank_reg <= ~wr_bank_reg;
      end
      if (row_acc) begin
        rd_beat_reg <= rd_beat_reg + 2'd1;
        if (rd_last) rd_bank_reg <= ~rd_bank_reg;
      end
    end
  end

  // Beat k carries columns 2k and 2k+1; lane cl*8+r holds row r of column 2k+cl.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            mem_reg[b][r][c] <= '0;
    end else if (col_acc) begin
      for (int cl = 0; cl < 2; cl++)
        for (int r = 0; r < 8; r++)
          mem_reg[wr_bank_reg][r][{wr_beat_reg, cl[0]}] <= col_data[(cl*8+r)*EW +: EW];
    end
  end

  // Lane rl*8+c of the output beat is row 2k+rl, column c of the draining bank.
  for (genvar gi = 0; gi < 16; gi++) begin : g_row_lane
    localparam int RL = gi / 8;
    localparam int C  = gi % 8;
    assign row_data[gi*EW +: EW] = mem_reg[rd_bank_reg][{rd_beat_reg, 1'(RL)}][C];
  end

endmodule
